bus_port_endpoint: RTL and testbench

- RTL device-side endpoint for one slot of the bs_gnrtr_n_rbtr bus: the far end of the pndng/pop/D_pop and push/D_push interface that the arbiter drives.
- Host TX side enqueues packets into a TX FIFO. The bus pops them from it.
- Bus pushes land in an RX FIFO, which the host drains. Packet = {dest[7:0], payload[pckg_sz-9:0]}.
- One instance per drvr slot; replaces the behavioural driver FIFO when integrating real devices.

---
 rtl/bus_port_endpoint.sv | 196 +++++++++++++++++++
 tb/tb_bus_port_endpoint.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_port_endpoint.sv
// bus_port_endpoint
//   Device-side endpoint for one drvr slot of the bs_gnrtr_n_rbtr bus.
//   The host enqueues packets into a TX FIFO that the bus drains through
//   pndng/pop/D_pop. Bus pushes (push/D_push) land in an RX FIFO that the
//   host drains. Packet layout: {dest[7:0], payload[pckg_sz-9:0]}.
//
//   Optional feature: define BUS_PORT_RX_FILTER_EN to accept only pushes
//   whose dest field equals id or broadcast. Other pushes are dropped.
//
// Parameters
//   pckg_sz    packet width in bits (>= 9)
//   depth      entries per FIFO, power of two, >= 2
//   id         this endpoint's 8-bit address
//   broadcast  broadcast destination address
//
// Ports
//   clk, reset          clock; synchronous active-high reset
//   tx_valid/tx_ready   host -> TX FIFO handshake, with tx_dest and tx_data
//   pndng, D_pop, pop   bus side of the TX FIFO (first-word-fall-through)
//   push, D_push        bus delivers a packet to the RX FIFO
//   rx_valid/rx_ready   RX FIFO -> host handshake, with rx_dest and rx_data
//   tx_cnt, rx_cnt      saturating counts of bus pops and accepted pushes
//   drop_cnt            saturating count of dropped pushes
//   err_underflow       sticky: pop seen while the TX FIFO was empty
module bus_port_endpoint #(
    parameter int unsigned pckg_sz   = 20,
    parameter int unsigned depth     = 8,
    parameter logic [7:0]  id        = 8'd0,
    parameter logic [7:0]  broadcast = 8'hFF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tx_valid,
    output logic               tx_ready,
    input  logic [7:0]         tx_dest,
    input  logic [pckg_sz-9:0] tx_data,
    output logic               pndng,
    output logic [pckg_sz-1:0] D_pop,
    input  logic               pop,
    input  logic               push,
    input  logic [pckg_sz-1:0] D_push,
    output logic               rx_valid,
    input  logic               rx_ready,
    output logic [7:0]         rx_dest,
    output logic [pckg_sz-9:0] rx_data,
    output logic [15:0]        tx_cnt,
    output logic [15:0]        rx_cnt,
    output logic [15:0]        drop_cnt,
    output logic               err_underflow
);

    localparam int unsigned AW = $clog2(depth);

`ifdef BUS_PORT_RX_FILTER_EN
    localparam bit FILTER_EN = 1'b1;
`else
    localparam bit FILTER_EN = 1'b0;
`endif

    function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
        return (en && (v != '1)) ? v + 16'd1 : v;
    endfunction

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    logic [pckg_sz-1:0] tx_mem [depth];
    logic [AW:0]        tx_wp, tx_rp;
    logic               tx_empty, tx_full, tx_wr, tx_rd, tx_under;

    assign tx_empty = (tx_wp == tx_rp);
    assign tx_full  = (tx_wp[AW] != tx_rp[AW]) && (tx_wp[AW-1:0] == tx_rp[AW-1:0]);

    // Handshake outputs are forced low while reset is held so the bus and
    // host see an idle endpoint from the very first reset cycle.
    assign tx_ready = ~reset & ~tx_full;
    assign pndng    = ~reset & ~tx_empty;
    assign D_pop    = pndng ? tx_mem[tx_rp[AW-1:0]] : '0;

    // tx_ready reflects the pre-pop state, so a write while full is refused
    // even when the bus pops in the same cycle.
    assign tx_wr    = tx_valid & tx_ready;
    assign tx_rd    = pop & pndng;
    assign tx_under = pop & ~pndng;

    always_ff @(posedge clk) begin
        if (tx_wr)
            tx_mem[tx_wp[AW-1:0]] <= {tx_dest, tx_data};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_wp         <= '0;
            tx_rp         <= '0;
            tx_cnt        <= '0;
            err_underflow <= 1'b0;
        end else begin
            if (tx_wr)
                tx_wp <= tx_wp + 1'b1;
            if (tx_rd)
                tx_rp <= tx_rp + 1'b1;
            tx_cnt <= sat_inc(tx_cnt, tx_rd);
            if (tx_under)
                err_underflow <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // RX FIFO
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        RX_IDLE,
        RX_ACCEPT,
        RX_DROP
    } rx_event_t;

    rx_event_t          rx_state, rx_next;
    logic [pckg_sz-1:0] rx_mem [depth];
    logic [AW:0]        rx_wp, rx_rp;
    logic               rx_empty, rx_full, rx_rd, rx_space, rx_addr_ok;
    logic               rx_wr, rx_drop;
    logic [7:0]         push_dest;
    logic [pckg_sz-1:0] rx_head;

    assign rx_empty = (rx_wp == rx_rp);
    assign rx_full  = (rx_wp[AW] != rx_rp[AW]) && (rx_wp[AW-1:0] == rx_rp[AW-1:0]);

    assign rx_valid = ~reset & ~rx_empty;
    assign rx_head  = rx_valid ? rx_mem[rx_rp[AW-1:0]] : '0;
    assign rx_dest  = rx_head[pckg_sz-1:pckg_sz-8];
    assign rx_data  = rx_head[pckg_sz-9:0];
    assign rx_rd    = rx_valid & rx_ready;

    // A host read in the same cycle frees the head slot, so a push into a
    // full FIFO still fits.
    assign rx_space   = ~rx_full | rx_rd;
    assign push_dest  = D_push[pckg_sz-1:pckg_sz-8];
    assign rx_addr_ok = !FILTER_EN || (push_dest == id) || (push_dest == broadcast);

    // State register: last event, kept for debug visibility.
    always_ff @(posedge clk) begin
        if (reset)
            rx_state <= RX_IDLE;
        else
            rx_state <= rx_next;
    end

    // Next-state: every push cycle is decided on its own, independent of
    // the previous event.
    always_comb begin
        rx_next = RX_IDLE;
        case (rx_state)
            RX_IDLE, RX_ACCEPT, RX_DROP: begin
                if (push && !reset)
                    rx_next = (rx_space && rx_addr_ok) ? RX_ACCEPT : RX_DROP;
            end
            default: rx_next = RX_IDLE;
        endcase
    end

    // Outputs act on the event being decided this cycle.
    always_comb begin
        rx_wr   = 1'b0;
        rx_drop = 1'b0;
        case (rx_next)
            RX_ACCEPT: rx_wr   = 1'b1;
            RX_DROP:   rx_drop = 1'b1;
            default: begin
                rx_wr   = 1'b0;
                rx_drop = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rx_wr)
            rx_mem[rx_wp[AW-1:0]] <= D_push;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_wp    <= '0;
            rx_rp    <= '0;
            rx_cnt   <= '0;
            drop_cnt <= '0;
        end else begin
            if (rx_wr)
                rx_wp <= rx_wp + 1'b1;
            if (rx_rd)
                rx_rp <= rx_rp + 1'b1;
            rx_cnt   <= sat_inc(rx_cnt, rx_wr);
            drop_cnt <= sat_inc(drop_cnt, rx_drop);
        end
    end

endmodule

// File: tb/tb_bus_port_endpoint.sv
module tb_bus_port_endpoint;

    localparam int unsigned PS = 20;
    localparam int unsigned DP = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          tx_valid;
    logic          tx_ready;
    logic [7:0]    tx_dest;
    logic [PS-9:0] tx_data;
    logic          pndng;
    logic [PS-1:0] D_pop;
    logic          pop;
    logic          push;
    logic [PS-1:0] D_push;
    logic          rx_valid;
    logic          rx_ready;
    logic [7:0]    rx_dest;
    logic [PS-9:0] rx_data;
    logic [15:0]   tx_cnt, rx_cnt, drop_cnt;
    logic          err_underflow;

    int unsigned tests_run  = 0;
    int unsigned tests_fail = 0;

    logic [PS-1:0] tx_q[$];
    logic [PS-1:0] rx_q[$];
    logic [PS-1:0] exp_pkt;

    bus_port_endpoint #(
        .pckg_sz  (PS),
        .depth    (DP),
        .id       (8'd1),
        .broadcast(8'hFF)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .tx_dest      (tx_dest),
        .tx_data      (tx_data),
        .pndng        (pndng),
        .D_pop        (D_pop),
        .pop          (pop),
        .push         (push),
        .D_push       (D_push),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .rx_dest      (rx_dest),
        .rx_data      (rx_data),
        .tx_cnt       (tx_cnt),
        .rx_cnt       (rx_cnt),
        .drop_cnt     (drop_cnt),
        .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        tx_valid = 1'b0; tx_dest = '0; tx_data = '0;
        pop = 1'b0; push = 1'b0; D_push = '0; rx_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        tick();
        tx_q.delete();
        rx_q.delete();
    endtask

    task automatic tx_write(input logic [7:0] d, input logic [PS-9:0] p);
        tx_valid = 1'b1; tx_dest = d; tx_data = p;
        if (tx_ready === 1'b1) tx_q.push_back({d, p});
        tick();
        tx_valid = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        tick(); tick();
        tests_run++;
        if ({tx_ready, pndng, rx_valid, err_underflow} !== 4'b0000) begin
            tests_fail++;
            $display("FAIL reset_flags: got rdy/pnd/rxv/err=%b want 0000",
                     {tx_ready, pndng, rx_valid, err_underflow});
        end
        tests_run++;
        if ({D_pop, rx_dest, rx_data} !== '0) begin
            tests_fail++;
            $display("FAIL reset_data: got D_pop=%h rx=%h/%h want 0", D_pop, rx_dest, rx_data);
        end
        tests_run++;
        if ({tx_cnt, rx_cnt, drop_cnt} !== '0) begin
            tests_fail++;
            $display("FAIL reset_cnt: got %0d/%0d/%0d want 0/0/0", tx_cnt, rx_cnt, drop_cnt);
        end
        reset = 1'b0;
        tick();
        tests_run++;
        if (tx_ready !== 1'b1 || pndng !== 1'b0) begin
            tests_fail++;
            $display("FAIL post_reset: got tx_ready=%b pndng=%b want 1/0", tx_ready, pndng);
        end
    endtask

    task automatic test_tx_basic();
        do_reset();
        tx_write(8'h02, 12'h008);
        tests_run++;
        if (pndng !== 1'b1) begin
            tests_fail++;
            $display("FAIL tx_pndng: got %b want 1", pndng);
        end
        exp_pkt = tx_q.pop_front();
        tests_run++;
        if (D_pop !== exp_pkt || D_pop !== 20'h02008) begin
            tests_fail++;
            $display("FAIL tx_dpop: got %h want %h", D_pop, exp_pkt);
        end
        pop = 1'b1; tick(); pop = 1'b0;
        tests_run++;
        if (pndng !== 1'b0 || tx_cnt !== 16'd1) begin
            tests_fail++;
            $display("FAIL tx_after_pop: got pndng=%b tx_cnt=%0d want 0/1", pndng, tx_cnt);
        end
    endtask

    task automatic test_tx_full_underflow();
        do_reset();
        for (int i = 0; i < 8; i++) tx_write(8'h10 + 8'(i), 12'hA00 + 12'(i * 7));
        tests_run++;
        if (tx_ready !== 1'b0) begin
            tests_fail++;
            $display("FAIL tx_full_ready: got %b want 0", tx_ready);
        end
        tx_write(8'hEE, 12'hEEE);  // refused, nothing queued
        for (int i = 0; i < 8; i++) begin
            exp_pkt = tx_q.pop_front();
            tests_run++;
            if (pndng !== 1'b1 || D_pop !== exp_pkt) begin
                tests_fail++;
                $display("FAIL tx_order[%0d]: got pndng=%b D_pop=%h want 1/%h", i, pndng, D_pop, exp_pkt);
            end
            // On the first pop (still full) offer a write: tx_ready is low so it is refused.
            tx_valid = (i == 0); tx_dest = 8'h77; tx_data = 12'h777;
            pop = 1'b1; tick(); pop = 1'b0; tx_valid = 1'b0;
        end
        tests_run++;
        if (pndng !== 1'b0 || D_pop !== '0) begin
            tests_fail++;
            $display("FAIL tx_empty: got pndng=%b D_pop=%h want 0/0", pndng, D_pop);
        end
        pop = 1'b1; tick(); pop = 1'b0;
        tests_run++;
        if (err_underflow !== 1'b1 || tx_cnt !== 16'd8) begin
            tests_fail++;
            $display("FAIL tx_underflow: got err=%b tx_cnt=%0d want 1/8", err_underflow, tx_cnt);
        end
        // Write and pop together while empty: write kept, pop is an underflow.
        do_reset();
        tx_valid = 1'b1; tx_dest = 8'h05; tx_data = 12'h055; pop = 1'b1;
        tick();
        tx_valid = 1'b0; pop = 1'b0;
        tests_run++;
        if (pndng !== 1'b1 || D_pop !== 20'h05055 || err_underflow !== 1'b1 || tx_cnt !== 16'd0) begin
            tests_fail++;
            $display("FAIL tx_wr_pop_empty: got pndng=%b D_pop=%h err=%b cnt=%0d want 1/05055/1/0",
                     pndng, D_pop, err_underflow, tx_cnt);
        end
    endtask

    task automatic test_rx_overflow();
        do_reset();
        for (int i = 0; i < 9; i++) begin
            push = 1'b1; D_push = {8'h01, 12'h300 + 12'(i)};
            if (i < 8) rx_q.push_back(D_push);
            tick();
        end
        push = 1'b0;
        tests_run++;
        if (rx_cnt !== 16'd8 || drop_cnt !== 16'd1 || rx_valid !== 1'b1) begin
            tests_fail++;
            $display("FAIL rx_overflow: got rx_cnt=%0d drop=%0d rxv=%b want 8/1/1", rx_cnt, drop_cnt, rx_valid);
        end
        exp_pkt = rx_q.pop_front();
        tests_run++;
        if ({rx_dest, rx_data} !== exp_pkt) begin
            tests_fail++;
            $display("FAIL rx_head: got %h want %h", {rx_dest, rx_data}, exp_pkt);
        end
        push = 1'b1; D_push = {8'h01, 12'h3AB}; rx_ready = 1'b1;
        rx_q.push_back(D_push);
        tick();
        push = 1'b0; rx_ready = 1'b0;
        tests_run++;
        if (rx_cnt !== 16'd9 || drop_cnt !== 16'd1) begin
            tests_fail++;
            $display("FAIL rx_full_rdwr: got rx_cnt=%0d drop=%0d want 9/1", rx_cnt, drop_cnt);
        end
        rx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp_pkt = rx_q.pop_front();
            tests_run++;
            if (rx_valid !== 1'b1 || {rx_dest, rx_data} !== exp_pkt) begin
                tests_fail++;
                $display("FAIL rx_drain[%0d]: got v=%b %h want 1/%h", i, rx_valid, {rx_dest, rx_data}, exp_pkt);
            end
            tick();
        end
        tick();  // read while empty is ignored
        rx_ready = 1'b0;
        tests_run++;
        if (rx_valid !== 1'b0 || rx_cnt !== 16'd9 || {rx_dest, rx_data} !== '0) begin
            tests_fail++;
            $display("FAIL rx_empty: got v=%b cnt=%0d head=%h want 0/9/0", rx_valid, rx_cnt, {rx_dest, rx_data});
        end
    endtask

    task automatic test_filter();
        logic [PS-1:0] pk [3];
        logic [15:0]   exp_acc, exp_drop;
        pk[0] = {8'h01, 12'h0A1};
        pk[1] = {8'hFF, 12'h0B2};
        pk[2] = {8'h03, 12'h0C3};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            push = 1'b1; D_push = pk[i];
`ifdef BUS_PORT_RX_FILTER_EN
            if (i != 2) rx_q.push_back(pk[i]);
`else
            rx_q.push_back(pk[i]);
`endif
            tick();
        end
        push = 1'b0;
`ifdef BUS_PORT_RX_FILTER_EN
        exp_acc = 16'd2; exp_drop = 16'd1;
`else
        exp_acc = 16'd3; exp_drop = 16'd0;
`endif
        tests_run++;
        if (rx_cnt !== exp_acc || drop_cnt !== exp_drop) begin
            tests_fail++;
            $display("FAIL filter_cnt: got rx=%0d drop=%0d want %0d/%0d", rx_cnt, drop_cnt, exp_acc, exp_drop);
        end
        rx_ready = 1'b1;
        while (rx_q.size() != 0) begin
            exp_pkt = rx_q.pop_front();
            tests_run++;
            if (rx_valid !== 1'b1 || {rx_dest, rx_data} !== exp_pkt) begin
                tests_fail++;
                $display("FAIL filter_data: got v=%b %h want 1/%h", rx_valid, {rx_dest, rx_data}, exp_pkt);
            end
            tick();
        end
        rx_ready = 1'b0;
        tests_run++;
        if (rx_valid !== 1'b0) begin
            tests_fail++;
            $display("FAIL filter_leftover: got rx_valid=%b want 0", rx_valid);
        end
    endtask

    task automatic test_reset_mid_traffic();
        do_reset();
        for (int i = 0; i < 4; i++) tx_write(8'h20 + 8'(i), 12'h100 + 12'(i));
        pop = 1'b1; tick(); pop = 1'b0;
        for (int i = 0; i < 2; i++) begin
            push = 1'b1; D_push = {8'h01, 12'h200 + 12'(i)}; tick();
        end
        push = 1'b0;
        tests_run++;
        if (pndng !== 1'b1 || rx_valid !== 1'b1 || tx_cnt !== 16'd1 || rx_cnt !== 16'd2) begin
            tests_fail++;
            $display("FAIL mid_pre: got pndng=%b rxv=%b tx=%0d rx=%0d want 1/1/1/2", pndng, rx_valid, tx_cnt, rx_cnt);
        end
        reset = 1'b1;
        tick();
        tests_run++;
        if (pndng !== 1'b0 || rx_valid !== 1'b0 || tx_ready !== 1'b0 ||
            {tx_cnt, rx_cnt, drop_cnt} !== '0) begin
            tests_fail++;
            $display("FAIL mid_reset: got pndng=%b rxv=%b rdy=%b cnt=%0d/%0d/%0d want 0/0/0/0/0/0",
                     pndng, rx_valid, tx_ready, tx_cnt, rx_cnt, drop_cnt);
        end
        reset = 1'b0;
        tick();
        tests_run++;
        if (tx_ready !== 1'b1 || pndng !== 1'b0 || rx_valid !== 1'b0 || D_pop !== '0) begin
            tests_fail++;
            $display("FAIL mid_after: got rdy=%b pndng=%b rxv=%b D_pop=%h want 1/0/0/0",
                     tx_ready, pndng, rx_valid, D_pop);
        end
        tx_q.delete();
        rx_q.delete();
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_tx_basic();
        test_tx_full_underflow();
        test_rx_overflow();
        test_filter();
        test_reset_mid_traffic();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_fail);
        $finish;
    end

endmodule
